// File: rtl/rim_pkg.sv
// Shared types and constants for the maze path checker.
//   state_t      : checker FSM states
//   err_t/ERR_*  : verdict codes, 0 = legal path
//   coord_t      : one (row, col) maze coordinate
//   step_flags_t : per-coordinate flags produced by rim_step_check
//   step_code()  : folds one coordinate's flags into an error code, lowest code wins
package rim_pkg;
  localparam int MAZE_DIM     = 8;
  localparam int MAX_STEPS    = 64;
  localparam int WAIT_TIMEOUT = 512;

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_PATH, CHECK, REPORT} state_t;

  typedef logic [2:0] err_t;
  localparam err_t ERR_NONE    = 3'd0;
  localparam err_t ERR_START   = 3'd1;
  localparam err_t ERR_ADJ     = 3'd2;
  localparam err_t ERR_WALL    = 3'd3;
  localparam err_t ERR_END     = 3'd4;
  localparam err_t ERR_LONG    = 3'd5;
  localparam err_t ERR_TIMEOUT = 3'd6;
  localparam err_t ERR_LOAD    = 3'd7;

  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
  } coord_t;

  typedef struct packed {
    logic adj;
    logic wall;
    logic is_start;
    logic is_end;
  } step_flags_t;

  // Priority order matches the numeric codes, so the lowest code wins when
  // one coordinate trips several checks.
  function automatic err_t step_code(input logic first, input step_flags_t f,
                                     input logic too_long);
    if (first && !f.is_start) return ERR_START;
    if (!first && !f.adj)     return ERR_ADJ;
    if (f.wall)               return ERR_WALL;
    if (too_long)             return ERR_LONG;
    return ERR_NONE;
  endfunction
endpackage

// File: rtl/rim_step_check.sv
// Combinational per-coordinate checks.
//   cur      : coordinate being consumed
//   prev     : previously consumed coordinate
//   row_bits : maze row cur.row (bit 7 = column 0), 1 = wall
//   flags    : adjacency to prev, wall hit, is (0,0), is (7,7)
module rim_step_check
  import rim_pkg::*;
(
  input  coord_t                    cur,
  input  coord_t                    prev,
  input  logic [MAZE_DIM-1:0]       row_bits,
  output step_flags_t               flags
);
  logic signed [3:0] dr, dc;
  logic [3:0]        adr, adc;

  always_comb begin
    // Zero-extended 4-bit signed differences: col 7 -> col 0 is a distance of
    // 7, never 1, so there is no wrap-around adjacency.
    dr  = $signed({1'b0, cur.row}) - $signed({1'b0, prev.row});
    dc  = $signed({1'b0, cur.col}) - $signed({1'b0, prev.col});
    adr = dr[3] ? 4'(-dr) : 4'(dr);
    adc = dc[3] ? 4'(-dc) : 4'(dc);
    flags.adj      = (adr + adc) == 4'd1;
    flags.wall     = row_bits[3'd7 - cur.col];
    flags.is_start = (cur == '0);
    flags.is_end   = (cur.row == 3'd7) && (cur.col == 3'd7);
  end
endmodule

// File: rtl/rim_path_checker.sv
// Loads an 8x8 maze row by row, then checks a streamed path from (0,0) to
// (7,7) through open cells with 4-adjacent steps.
//   clk, rst_n           : clock, async active-low reset
//   in_valid, maze       : 8 consecutive maze rows, row 0 first
//   path_valid, path_row,
//   path_col             : contiguous path coordinates, one per cycle
//   done                 : one-cycle verdict pulse
//   pass, err_code       : verdict, held until the next maze load starts
module rim_path_checker
  import rim_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] maze,
  input  logic       path_valid,
  input  logic [2:0] path_row,
  input  logic [2:0] path_col,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_code
);
  state_t                            state, state_nxt;
  logic [MAZE_DIM-1:0][MAZE_DIM-1:0] grid;
  logic [2:0]                        row_cnt;
  logic [8:0]                        wait_cnt;
  logic [6:0]                        step_cnt;
  coord_t                            prev, cur;
  logic                              last_end;
  step_flags_t                       flags;

  logic load_start, load_row, load_fault, timeout;
  logic first, consume, path_end, finish;
  err_t coord_err, fin_err;

  assign cur = {path_row, path_col};

  rim_step_check u_step (
    .cur      (cur),
    .prev     (prev),
    .row_bits (grid[path_row]),
    .flags    (flags)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (in_valid) state_nxt = LOAD;
      LOAD:      if (!in_valid)             state_nxt = REPORT;
                 else if (row_cnt == 3'd7)  state_nxt = WAIT_PATH;
      WAIT_PATH: if (load_fault || timeout) state_nxt = REPORT;
                 else if (path_valid)       state_nxt = CHECK;
      CHECK:     if (!path_valid)           state_nxt = REPORT;
      REPORT:    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    load_start = (state == IDLE) && in_valid;
    load_row   = (state == LOAD) && in_valid;
    // A strobe that drops early, or is still high on the cycle right after
    // the 8th row (first WAIT_PATH cycle), is a malformed load.
    load_fault = ((state == LOAD) && !in_valid) ||
                 ((state == WAIT_PATH) && (wait_cnt == '0) && in_valid);
    timeout    = (state == WAIT_PATH) && !path_valid && !load_fault &&
                 (wait_cnt == 9'(WAIT_TIMEOUT - 1));
    first      = (state == WAIT_PATH);
    consume    = path_valid && !load_fault &&
                 ((state == WAIT_PATH) || (state == CHECK));
    path_end   = (state == CHECK) && !path_valid;
    finish     = load_fault || timeout || path_end;
    coord_err  = step_code(first, flags, step_cnt >= 7'(MAX_STEPS));
    fin_err    = err_code;
    if (load_fault)                                fin_err = ERR_LOAD;
    else if (timeout)                              fin_err = ERR_TIMEOUT;
    else if ((err_code == ERR_NONE) && !last_end)  fin_err = ERR_END;
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done     <= 1'b0;
      pass     <= 1'b0;
      err_code <= ERR_NONE;
      grid     <= '0;
      row_cnt  <= '0;
      wait_cnt <= '0;
      step_cnt <= '0;
      prev     <= '0;
      last_end <= 1'b0;
    end else begin
      done <= finish;
      if (load_start) begin
        grid[0]  <= maze;
        row_cnt  <= 3'd1;
        wait_cnt <= '0;
        step_cnt <= '0;
        prev     <= '0;
        last_end <= 1'b0;
        pass     <= 1'b0;
        err_code <= ERR_NONE;
      end
      if (load_row) begin
        grid[row_cnt] <= maze;
        row_cnt       <= row_cnt + 3'd1;
      end
      if (state == WAIT_PATH) wait_cnt <= wait_cnt + 9'd1;
      if (consume) begin
        prev     <= cur;
        last_end <= flags.is_end;
        if (step_cnt != 7'(MAX_STEPS + 1)) step_cnt <= step_cnt + 7'd1;
        // Only the first error sticks.
        if (err_code == ERR_NONE) err_code <= coord_err;
      end
      if (finish) begin
        err_code <= fin_err;
        pass     <= (fin_err == ERR_NONE);
      end
    end
  end
endmodule

// File: tb/tb_rim_path_checker.sv
module tb_rim_path_checker;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] maze = '0;
  logic       path_valid = 1'b0;
  logic [2:0] path_row = '0;
  logic [2:0] path_col = '0;
  logic       done, pass;
  logic [2:0] err_code;

  int passed = 0;
  int total  = 0;

  logic [7:0] rows [8];
  logic [5:0] cq [$];

  rim_path_checker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .maze       (maze),
    .path_valid (path_valid),
    .path_row   (path_row),
    .path_col   (path_col),
    .done       (done),
    .pass       (pass),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic set_rows(input logic [7:0] fill);
    for (int i = 0; i < 8; i++) rows[i] = fill;
  endtask

  // Drives n strobed rows (rows beyond 7 are zero) starting at a negedge.
  task automatic load_maze(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      maze     = (i < 8) ? rows[i] : 8'h00;
      @(negedge clk);
    end
    in_valid = 1'b0;
    maze     = 8'h00;
  endtask

  task automatic push(input int r, input int c);
    cq.push_back({3'(r), 3'(c)});
  endtask

  task automatic snake();
    for (int c = 0; c < 8; c++) push(0, c);
    for (int r = 1; r < 8; r++) push(r, 7);
  endtask

  task automatic send_path(output int early);
    early = 0;
    foreach (cq[i]) begin
      path_valid = 1'b1;
      path_row   = cq[i][5:3];
      path_col   = cq[i][2:0];
      @(negedge clk);
      if (done) early++;
    end
    path_valid = 1'b0;
    cq.delete();
  endtask

  task automatic expect_verdict(input string tag, input int early, input logic [2:0] exp_err);
    chk({tag, "_early_done"}, early, 0);
    @(negedge clk);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_err"}, err_code, exp_err);
    chk({tag, "_pass"}, pass, exp_err == 3'd0);
    @(negedge clk);
    chk({tag, "_done_clr"}, done, 0);
  endtask

  initial begin
    int early, n;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_code, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Open maze, legal snake path
    set_rows(8'h00);
    load_maze(8);
    snake();
    send_path(early);
    expect_verdict("open_snake", early, 3'd0);
    repeat (3) @(negedge clk);
    chk("open_snake_pass_held", pass, 1);

    // (3,7) is a wall on the same path
    set_rows(8'h00); rows[3] = 8'h01;
    load_maze(8);
    snake();
    send_path(early);
    expect_verdict("wall_3_7", early, 3'd3);

    // Diagonal step, then an adjacent wall hit: first error (2) sticks
    set_rows(8'h00); rows[1] = 8'h10;
    load_maze(8);
    push(0, 0); push(0, 1); push(1, 2); push(1, 3);
    send_path(early);
    expect_verdict("diag_then_wall", early, 3'd2);

    // Bad start
    set_rows(8'h00);
    load_maze(8);
    push(1, 0); push(2, 0);
    send_path(early);
    expect_verdict("bad_start", early, 3'd1);

    // Legal steps ending at (7,6)
    load_maze(8);
    for (int r = 0; r < 8; r++) push(r, 0);
    for (int c = 1; c < 7; c++) push(7, c);
    send_path(early);
    expect_verdict("end_7_6", early, 3'd4);

    // (0,7) -> (0,0) must not count as adjacent
    load_maze(8);
    for (int c = 0; c < 8; c++) push(0, c);
    push(0, 0);
    send_path(early);
    expect_verdict("no_wrap", early, 3'd2);

    // Exactly 64 coordinates: not too long, just wrong end
    load_maze(8);
    for (int k = 0; k < 64; k++) push(0, k % 2);
    send_path(early);
    expect_verdict("steps_64", early, 3'd4);

    // 65 coordinates: too long
    load_maze(8);
    for (int k = 0; k < 65; k++) push(0, k % 2);
    send_path(early);
    expect_verdict("steps_65", early, 3'd5);

    // Strobe only 5 cycles
    load_maze(5);
    expect_verdict("short_load", 0, 3'd7);

    // Strobe 9 cycles: the verdict is already up when the 9th row ends
    load_maze(9);
    chk("long_load_done", done, 1);
    chk("long_load_err", err_code, 7);
    @(negedge clk);
    chk("long_load_done_clr", done, 0);

    // No path for 512 cycles after the load
    load_maze(8);
    n = 0;
    while (!done && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", n, 512);
    chk("timeout_err", err_code, 6);
    chk("timeout_pass", pass, 0);
    @(negedge clk);
    chk("timeout_done_clr", done, 0);

    // Reset at path step 4 (an error already latched)
    load_maze(8);
    for (int r = 1; r < 5; r++) begin
      path_valid = 1'b1;
      path_row   = 3'(r);
      path_col   = 3'd0;
      @(negedge clk);
    end
    chk("pre_rst_err", err_code, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_err", err_code, 0);
    chk("mid_rst_pass", pass, 0);
    chk("mid_rst_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // path_valid still high in IDLE must be ignored
    repeat (2) @(negedge clk);
    path_valid = 1'b0;
    early = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) early++;
    end
    chk("post_rst_no_done", early, 0);
    chk("post_rst_err", err_code, 0);

    load_maze(8);
    snake();
    send_path(early);
    expect_verdict("post_rst_snake", early, 3'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/rim_path_checker.md
RIM_PATH_CHECKER -- requirements
Module: rim_path_checker

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 in_valid  input  1  maze row strobe; high for exactly 8 consecutive cycles per maze.
REQ-004 maze  input  8  one maze row per in_valid cycle, row 0 first; bit 7 = column 0, bit 0 = column 7; 0 = open, 1 = wall.
REQ-005 path_valid  input  1  high while path coordinates are streamed, one coordinate per cycle, contiguous.
REQ-006 path_row  input  3  row of the current path coordinate.
REQ-007 path_col  input  3  column of the current path coordinate.
REQ-008 done  output  1  one-cycle pulse when a verdict is available.
REQ-009 pass  output  1  1 = last checked path legal; held until next maze load starts.
REQ-010 err_code  output  3  first error detected; held with pass.

Function
REQ-011 FSM states SHALL be IDLE, LOAD, WAIT_PATH, CHECK, REPORT.
REQ-012 IDLE -> LOAD on in_valid=1, storing that cycle's row as row 0; pass and err_code clear to 0 on that edge.
REQ-013 LOAD stores rows 1..7 on the following cycles into an 8x8 bit array; after the 8th row -> WAIT_PATH.
REQ-014 in_valid falling before 8 rows, or staying high a 9th cycle -> err_code=7, done pulse, state REPORT.
REQ-015 WAIT_PATH -> CHECK on the first path_valid=1 cycle; that coordinate SHALL be checked in that same cycle.
REQ-016 WAIT_PATH with no path_valid for 512 cycles after LOAD exit -> err_code=6, done, REPORT.
REQ-017 First coordinate not (0,0) -> error code 1.
REQ-018 Any later coordinate not 4-adjacent to the previous one (|dr|+|dc| != 1) -> code 2.
REQ-019 Any coordinate on a wall cell -> code 3.
REQ-020 More than 64 coordinates in one path -> code 5; 7-bit step counter saturates at 65.
REQ-021 Only the first error SHALL be latched; later errors ignored; coordinate consumption continues until path_valid falls.
REQ-022 Two errors on the same coordinate -> lower code wins.
REQ-023 CHECK -> REPORT on first cycle with path_valid=0; last coordinate not (7,7) with no prior error -> code 4.
REQ-024 done SHALL pulse exactly one cycle, one clock after path_valid falls (registered); pass=1 iff err_code=0.
REQ-025 REPORT -> IDLE after the done cycle; pass/err_code hold until the next load begins.
REQ-026 in_valid asserted in WAIT_PATH or CHECK SHALL be ignored; path_valid in IDLE or LOAD SHALL be ignored.
REQ-027 Coordinate arithmetic SHALL use 4-bit signed differences; no wrap-around adjacency (col 7 to col 0 is not adjacent).

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, done=0, pass=0, err_code=0, counters 0, maze array 0.
REQ-029 Reset mid-LOAD or mid-CHECK SHALL discard all partial data; no done pulse after release.

Structure
REQ-030 Package rim_pkg SHALL hold the state enum, error code constants (0..7), MAZE_DIM=8, MAX_STEPS=64, WAIT_TIMEOUT=512.
REQ-031 One combinational sub-module rim_step_check SHALL compute adjacency, wall hit and start/end flags for one coordinate.

Verification
REQ-032 All-open maze, path (0,0),(0,1)..(0,7),(1,7)..(7,7) (15 steps) -> done one cycle after path_valid falls, pass=1, err_code=0.
REQ-033 Same maze with (3,7) a wall, same path -> pass=0, err_code=3.
REQ-034 Path (0,0),(0,1),(1,2) -> err_code=2; first-error hold verified by later wall hit still reporting 2.
REQ-035 Path starting (1,0) -> err_code=1; valid path ending (7,6) -> err_code=4.
REQ-036 in_valid high only 5 cycles -> err_code=7; loaded maze with no path for 512 cycles -> err_code=6.
REQ-037 rst_n pulsed low at path step 4 -> outputs 0 immediately, no done, next full maze+path verified correctly.
